// File: rtl/rr_enc_pkg.sv
// rr_enc_pkg: shared FSM state type and default line count for the round-robin index encoder.
package rr_enc_pkg;

    typedef enum logic {IDLE, HOLD} state_t;

    localparam int N_DEFAULT = 32;

endpackage

// File: rtl/rr_find_first.sv
// rr_find_first: circular first-set search over req starting at start, plus a >1-bits flag.
module rr_find_first #(
    parameter int N = 32,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx,
    output logic         multi
);

    logic [N-1:0] w_masked;
    logic [W-1:0] w_hi_idx;
    logic [W-1:0] w_lo_idx;

    assign w_masked = req & ~((N'(1) << start) - N'(1));

    // Descending scan leaves the lowest set bit as the last assignment.
    always_comb begin
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_masked[i]) w_hi_idx = W'(i);
            if (req[i]) w_lo_idx = W'(i);
        end
    end

    assign found = |req;
    assign idx   = |w_masked ? w_hi_idx : w_lo_idx;
    assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/rr_index_encoder.sv
// rr_index_encoder: registered round-robin priority encoder with valid/ready output handshake.
module rr_index_encoder
    import rr_enc_pkg::*;
#(
    parameter int N = N_DEFAULT,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_multi
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_ptr;
    logic [W-1:0] r_idx;
    logic [N-1:0] r_onehot;
    logic         r_valid;
    logic         r_multi;
    logic [W-1:0] w_start;
    logic         w_advance;
    logic         w_found;
    logic [W-1:0] w_idx;
    logic         w_multi;

    rr_find_first #(.N(N)) u_find (
        .req   (req),
        .start (w_start),
        .found (w_found),
        .idx   (w_idx),
        .multi (w_multi)
    );

    // After a handshake the just-granted line is searched last.
    always_comb begin
        w_start     = (r_state == HOLD) ? r_idx + W'(1) : r_ptr;
        w_advance   = (r_state == IDLE) || out_ready;
        w_state_nxt = r_state;
        if (w_advance) w_state_nxt = w_found ? HOLD : IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_multi  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_advance) begin
                if (r_state == HOLD) r_ptr <= r_idx + W'(1);
                r_valid  <= w_found;
                r_idx    <= w_found ? w_idx : r_idx;
                r_onehot <= w_found ? N'(1) << w_idx : '0;
                r_multi  <= w_multi;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_idx    = r_idx;
    assign out_onehot = r_onehot;
    assign out_multi  = r_multi;

endmodule

// File: tb/tb_rr_index_encoder.sv
// tb_rr_index_encoder: directed scenarios plus random traffic checked against a circular-search model.
module tb_rr_index_encoder;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req = '1;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [4:0]    out_idx;
    logic [N-1:0]  out_onehot;
    logic          out_multi;

    int checks = 0;
    int failures = 0;

    bit m_valid;
    int m_idx;
    int m_ptr;
    bit m_multi;

    rr_index_encoder #(.N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_multi  (out_multi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] r, input int s);
        for (int k = 0; k < N; k++)
            if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 0;
        m_multi = 0;
    endtask

    task automatic step(input logic [N-1:0] r, input bit rdy);
        int s;
        int w;
        req = r;
        out_ready = rdy;
        @(posedge clk);
        if (!m_valid || rdy) begin
            s = m_valid ? (m_idx + 1) % N : m_ptr;
            if (m_valid) m_ptr = (m_idx + 1) % N;
            w = winner(r, s);
            m_valid = (w >= 0);
            if (w >= 0) m_idx = w;
            m_multi = ($countones(r) > 1);
        end
        #1;
        chk("valid", 32'(out_valid), 32'(m_valid));
        chk("onehot", out_onehot, m_valid ? 32'(1) << m_idx : 32'(0));
        if (m_valid) begin
            chk("idx", 32'(out_idx), 32'(m_idx));
            chk("multi", 32'(out_multi), 32'(m_multi));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_onehot", out_onehot, 32'd0);
        chk("rst_multi", 32'(out_multi), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int seq [6] = '{0, 2, 31, 0, 2, 31};
        model_reset();
        #2;
        chk("por_valid", 32'(out_valid), 32'd0);
        chk("por_idx", 32'(out_idx), 32'd0);
        chk("por_onehot", out_onehot, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        step(32'h0000_0100, 1'b1);
        chk("single_idx", 32'(out_idx), 32'd8);
        chk("single_onehot", out_onehot, 32'h100);
        step(32'h0, 1'b1);
        chk("single_idle", 32'(out_valid), 32'd0);

        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            step(32'h8000_0005, 1'b1);
            chk("rot_idx", 32'(out_idx), 32'(seq[i]));
            chk("rot_multi", 32'(out_multi), 32'd1);
        end

        pulse_reset();
        step(32'h8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(32'h10, 1'b0);
            chk("bp_idx", 32'(out_idx), 32'd3);
        end
        step(32'h10, 1'b1);
        chk("bp_next", 32'(out_idx), 32'd4);

        pulse_reset();
        step(32'h4000_0000, 1'b0);
        step(32'h8000_0001, 1'b1);
        chk("wrap_31", 32'(out_idx), 32'd31);
        step(32'h8000_0001, 1'b1);
        chk("wrap_0", 32'(out_idx), 32'd0);
        step(32'h0, 1'b1);
        step(32'h8000_0001, 1'b0);
        chk("wrap_ptr1", 32'(out_idx), 32'd31);

        pulse_reset();
        step(32'h0002_0000, 1'b0);
        chk("mid_17", 32'(out_idx), 32'd17);
        pulse_reset();
        step(32'h0002_0002, 1'b0);
        chk("mid_first", 32'(out_idx), 32'd1);

        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = N'(1) << $urandom_range(0, N - 1);
                2: r = $urandom & $urandom & $urandom;
                default: r = $urandom;
            endcase
            if ($urandom_range(0, 199) == 0) pulse_reset();
            step(r, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
